iter_div_seq: RTL and testbench

Parametrised multi-cycle integer divider with valid/ready handshakes on both sides. It supports per-operation signed/unsigned mode, a configurable number of quotient bits retired per cycle, and explicit divide-by-zero reporting. It is the general-purpose successor to the fixed-width unsigned iterative divider. It sits behind issue logic that can stall, and in front of consumers that can apply backpressure.

---
 rtl/iter_div_seq.sv | 137 +++++++++++++
 tb/tb_iter_div_seq.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_div_seq.sv
// iter_div_seq: multi-cycle restoring integer divider, signed or unsigned per operation.
// Each ITER cycle retires K quotient bits; then one FIX cycle applies signs and the
// divide-by-zero result. Valid/ready handshakes on both sides.
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous active-low reset
//   in_valid/ready   operand handshake (in_ready high only in IDLE)
//   in_signed        1 = two's-complement operation
//   left, right      dividend, divisor (sampled on the accepting edge only)
//   out_valid/ready  result handshake (out_valid high only in DONE)
//   out_quotient     quotient
//   out_remainder    remainder
//   out_div_by_zero  divisor was zero for this result
module iter_div_seq #(
    parameter int unsigned W = 32,
    parameter int unsigned K = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_signed,
    input  logic [W-1:0] left,
    input  logic [W-1:0] right,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_quotient,
    output logic [W-1:0] out_remainder,
    output logic         out_div_by_zero
);

    localparam int unsigned Steps = W / K;
    localparam int unsigned CntW  = (Steps > 1) ? $clog2(Steps) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(Steps - 1);

    typedef enum logic [1:0] {StIdle, StIter, StFix, StDone} state_t;

    state_t          state;
    logic [W:0]      rem;
    logic [W-1:0]    dvd;        // dividend magnitude, shifts into the quotient
    logic [W-1:0]    dsr;        // divisor magnitude
    logic [CntW-1:0] cnt;
    logic            op_signed;
    logic            neg_dvd;
    logic            neg_dsr;
    logic            dsr_zero;

    logic [W:0]      rem_nxt;
    logic [W-1:0]    dvd_nxt;
    logic [W-1:0]    q_fix;
    logic [W-1:0]    r_fix;

    assign in_ready  = (state == StIdle);
    assign out_valid = (state == StDone);

    // K unrolled restoring steps on {rem, dvd}.
    always_comb begin
        rem_nxt = rem;
        dvd_nxt = dvd;
        for (int unsigned i = 0; i < K; i++) begin
            rem_nxt = {rem_nxt[W-1:0], dvd_nxt[W-1]};
            dvd_nxt = {dvd_nxt[W-2:0], 1'b0};
            if (rem_nxt >= {1'b0, dsr}) begin
                rem_nxt    = rem_nxt - {1'b0, dsr};
                dvd_nxt[0] = 1'b1;
            end
        end
    end

    // With a zero divisor every step subtracts nothing, so the remainder ends up
    // holding |left|; the normal remainder sign fix then restores left exactly.
    always_comb begin
        if (dsr_zero) begin
            q_fix = '1;
        end else if (op_signed && (neg_dvd ^ neg_dsr)) begin
            q_fix = -dvd;
        end else begin
            q_fix = dvd;
        end
        r_fix = (op_signed && neg_dvd) ? -rem[W-1:0] : rem[W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= StIdle;
            rem             <= '0;
            dvd             <= '0;
            dsr             <= '0;
            cnt             <= '0;
            op_signed       <= 1'b0;
            neg_dvd         <= 1'b0;
            neg_dsr         <= 1'b0;
            dsr_zero        <= 1'b0;
            out_quotient    <= '0;
            out_remainder   <= '0;
            out_div_by_zero <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (in_valid) begin
                        op_signed <= in_signed;
                        neg_dvd   <= left[W-1];
                        neg_dsr   <= right[W-1];
                        dsr_zero  <= (right == '0);
                        dvd       <= (in_signed && left[W-1]) ? -left : left;
                        dsr       <= (in_signed && right[W-1]) ? -right : right;
                        rem       <= '0;
                        cnt       <= '0;
                        state     <= StIter;
                    end
                end
                StIter: begin
                    rem <= rem_nxt;
                    dvd <= dvd_nxt;
                    cnt <= cnt + CntW'(1);
                    if (cnt == CntLast) begin
                        state <= StFix;
                    end
                end
                StFix: begin
                    out_quotient    <= q_fix;
                    out_remainder   <= r_fix;
                    out_div_by_zero <= dsr_zero;
                    state           <= StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_div_seq.sv
module tb_iter_div_seq;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
    } exp_t;

    typedef struct {
        string      name;
        logic [7:0] a;
        logic [7:0] b;
        logic       s;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_signed = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] left = 8'h00;
    logic [7:0] right = 8'h00;
    logic       sel = 1'b0;   // 0 = K=1 instance, 1 = K=2 instance

    logic       in_ready_1, out_valid_1, dz_1;
    logic [7:0] q_1, r_1;
    logic       in_ready_2, out_valid_2, dz_2;
    logic [7:0] q_2, r_2;

    logic       in_ready_m, out_valid_m, dz_m;
    logic [7:0] q_m, r_m;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];
    vec_t vecs[6];

    always #5 clk = ~clk;

    iter_div_seq #(.W(8), .K(1)) dut1 (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid & ~sel),
        .in_ready        (in_ready_1),
        .in_signed       (in_signed),
        .left            (left),
        .right           (right),
        .out_valid       (out_valid_1),
        .out_ready       (out_ready & ~sel),
        .out_quotient    (q_1),
        .out_remainder   (r_1),
        .out_div_by_zero (dz_1)
    );

    iter_div_seq #(.W(8), .K(2)) dut2 (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid & sel),
        .in_ready        (in_ready_2),
        .in_signed       (in_signed),
        .left            (left),
        .right           (right),
        .out_valid       (out_valid_2),
        .out_ready       (out_ready & sel),
        .out_quotient    (q_2),
        .out_remainder   (r_2),
        .out_div_by_zero (dz_2)
    );

    assign in_ready_m  = sel ? in_ready_2  : in_ready_1;
    assign out_valid_m = sel ? out_valid_2 : out_valid_1;
    assign q_m         = sel ? q_2  : q_1;
    assign r_m         = sel ? r_2  : r_1;
    assign dz_m        = sel ? dz_2 : dz_1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic s);
        exp_t e;
        int sa, sb, qq, rr;
        e.dz = 1'b0;
        if (b == 8'h00) begin
            e.q  = 8'hFF;
            e.r  = a;
            e.dz = 1'b1;
        end else if (!s) begin
            e.q = a / b;
            e.r = a % b;
        end else begin
            sa  = int'($signed(a));
            sb  = int'($signed(b));
            qq  = sa / sb;
            rr  = sa % sb;
            e.q = qq[7:0];
            e.r = rr[7:0];
        end
        return e;
    endfunction

    // Wait for IDLE, offer one operand, push its expected result on acceptance.
    task automatic issue(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic s, input exp_t e, input logic rdy);
        int n = 0;
        while (!in_ready_m && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check({name, " in_ready before offer"}, 32'(in_ready_m), 32'd1);
        left      = a;
        right     = b;
        in_signed = s;
        in_valid  = 1'b1;
        out_ready = rdy;
        @(posedge clk);
        sb_q.push_back(e);
        #1;
        in_valid  = 1'b0;
        // Inputs must not matter after the accepting edge.
        left      = 8'($urandom);
        right     = 8'($urandom);
        in_signed = 1'($urandom);
    endtask

    // Wait for out_valid, check latency and in_ready, compare against the scoreboard.
    task automatic collect(input string name, input int lat);
        int   n = 0;
        logic ok = 1'b1;
        exp_t w;
        while (!out_valid_m && n < 100) begin
            if (in_ready_m) ok = 1'b0;
            @(posedge clk); #1; n++;
        end
        if (in_ready_m) ok = 1'b0;
        check({name, " latency"}, 32'(n), 32'(lat));
        check({name, " in_ready low while busy"}, 32'(ok), 32'd1);
        if (sb_q.size() == 0) begin
            check({name, " scoreboard entry present"}, 32'd0, 32'd1);
        end else begin
            w = sb_q.pop_front();
            check({name, " quotient"},  32'(q_m),  32'(w.q));
            check({name, " remainder"}, 32'(r_m),  32'(w.r));
            check({name, " div_by_zero"}, 32'(dz_m), 32'(w.dz));
        end
    endtask

    // Hold out_ready low; outputs must stay put and in_ready must stay low.
    task automatic hold_check(input string name, input int cycles);
        logic [7:0] q0 = q_m;
        logic [7:0] r0 = r_m;
        logic       d0 = dz_m;
        logic       ok = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (!out_valid_m || in_ready_m || q_m !== q0 || r_m !== r0 || dz_m !== d0) ok = 1'b0;
        end
        check({name, " held under backpressure"}, 32'(ok), 32'd1);
    endtask

    task automatic release_result(input string name);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, " out_valid after transfer"}, 32'(out_valid_m), 32'd0);
        check({name, " in_ready after transfer"}, 32'(in_ready_m), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [7:0] a, b;
        logic s;

        vecs[0] = '{"u 100/7",   8'd100, 8'd7,   1'b0, 8'd14,  8'd2,   1'b0};
        vecs[1] = '{"s -7/2",    8'hF9,  8'h02,  1'b1, 8'hFD,  8'hFF,  1'b0};
        vecs[2] = '{"s 7/-2",    8'h07,  8'hFE,  1'b1, 8'hFD,  8'h01,  1'b0};
        vecs[3] = '{"s min/-1",  8'h80,  8'hFF,  1'b1, 8'h80,  8'h00,  1'b0};
        vecs[4] = '{"u 0x55/0",  8'h55,  8'h00,  1'b0, 8'hFF,  8'h55,  1'b1};
        vecs[5] = '{"s 0xF0/0",  8'hF0,  8'h00,  1'b1, 8'hFF,  8'hF0,  1'b1};

        // Reset values
        #12;
        check("reset in_ready k1",  32'(in_ready_1),  32'd1);
        check("reset out_valid k1", 32'(out_valid_1), 32'd0);
        check("reset quotient k1",  32'(q_1), 32'd0);
        check("reset remainder k1", 32'(r_1), 32'd0);
        check("reset dz k1",        32'(dz_1), 32'd0);
        check("reset in_ready k2",  32'(in_ready_2),  32'd1);
        check("reset out_valid k2", 32'(out_valid_2), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // Directed table on K=1 (out_ready tied high)
        for (int i = 0; i < 6; i++) begin
            e = '{vecs[i].q, vecs[i].r, vecs[i].dz};
            issue(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].s, e, 1'b1);
            collect(vecs[i].name, 9);
            release_result(vecs[i].name);
        end

        // Backpressure with a second operand pending
        issue("bp 200/13", 8'd200, 8'd13, 1'b0, '{8'd15, 8'd5, 1'b0}, 1'b0);
        collect("bp 200/13", 9);
        left      = 8'd100;
        right     = 8'd7;
        in_signed = 1'b0;
        in_valid  = 1'b1;
        hold_check("bp 200/13", 6);
        check("bp quotient after hold",  32'(q_m), 32'd15);
        check("bp remainder after hold", 32'(r_m), 32'd5);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp out_valid after transfer", 32'(out_valid_m), 32'd0);
        check("bp not accepted on transfer edge", 32'(in_ready_m), 32'd1);
        @(posedge clk);
        sb_q.push_back('{8'd14, 8'd2, 1'b0});
        #1;
        in_valid = 1'b0;
        check("bp second accepted next edge", 32'(in_ready_m), 32'd0);
        collect("bp second 100/7", 9);
        release_result("bp second 100/7");

        // Reset during ITER with counter = 3
        issue("abort", 8'd100, 8'd7, 1'b0, '{8'd14, 8'd2, 1'b0}, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        sb_q.delete();
        #2;
        check("abort in_ready",  32'(in_ready_1),  32'd1);
        check("abort out_valid", 32'(out_valid_1), 32'd0);
        check("abort quotient",  32'(q_1), 32'd0);
        check("abort remainder", 32'(r_1), 32'd0);
        check("abort dz",        32'(dz_1), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        issue("post-abort 255/16", 8'd255, 8'd16, 1'b0, '{8'd15, 8'd15, 1'b0}, 1'b1);
        collect("post-abort 255/16", 9);
        release_result("post-abort 255/16");

        // Random sweep on K=1
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            s = 1'($urandom);
            case ($urandom_range(7, 0))
                0: b = 8'h00;
                1: begin a = 8'h80; b = 8'hFF; end
                2: b = 8'h01;
                default: ;
            endcase
            e = model(a, b, s);
            issue("rand k1", a, b, s, e, 1'($urandom));
            collect("rand k1", 9);
            if ($urandom_range(3, 0) == 0) hold_check("rand k1", 2);
            release_result("rand k1");
        end

        // K=2 instance
        sel = 1'b1;
        @(posedge clk); #1;
        issue("k2 100/7", 8'd100, 8'd7, 1'b0, '{8'd14, 8'd2, 1'b0}, 1'b1);
        collect("k2 100/7", 5);
        release_result("k2 100/7");
        for (int i = 0; i < 6; i++) begin
            e = '{vecs[i].q, vecs[i].r, vecs[i].dz};
            issue({"k2 ", vecs[i].name}, vecs[i].a, vecs[i].b, vecs[i].s, e, 1'b1);
            collect({"k2 ", vecs[i].name}, 5);
            release_result({"k2 ", vecs[i].name});
        end
        for (int i = 0; i < 200; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            s = 1'($urandom);
            if ($urandom_range(7, 0) == 0) b = 8'h00;
            e = model(a, b, s);
            issue("rand k2", a, b, s, e, 1'b1);
            collect("rand k2", 5);
            release_result("rand k2");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
